// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO port on the 8-bit CPU peripheral bus.
//   Per-pin direction, 2-stage input synchroniser and, when the GPIO_IRQ_EN
//   macro is defined, per-pin rising/falling edge capture into a sticky
//   status register driving a level interrupt. Without GPIO_IRQ_EN only
//   DATA/DIR/OUT exist, groups 2-4 read 0 and irq is tied low.
// Ports:
//   clk   - system clock, all state on rising edge
//   rst   - asynchronous active-low reset
//   AD    - [4:2] register group, [1:0] big-endian byte lane
//   DI    - write data, written when cs && ~rw
//   DO    - read data, combinational from AD
//   rw    - 1 = read, 0 = write
//   cs    - chip select
//   gpio  - pads, bit i driven with out[i] when dir[i]=1, else Z
//   irq   - registered active-high interrupt level
module gpio_irq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  inout  wire  [WIDTH-1:0] gpio,
  output logic             irq
);

  localparam int unsigned BUS_W = 32;
  localparam logic [BUS_W-1:0] IMPL_MASK = BUS_W'((64'd1 << WIDTH) - 64'd1);
  localparam logic [2:0] GRP_DATA = 3'd0;
  localparam logic [2:0] GRP_DIR  = 3'd1;
  localparam logic [2:0] GRP_OUT  = 3'd5;
`ifdef GPIO_IRQ_EN
  localparam logic [2:0] GRP_RISE = 3'd2;
  localparam logic [2:0] GRP_FALL = 3'd3;
  localparam logic [2:0] GRP_STAT = 3'd4;
`endif

  logic [2:0]       grp;
  logic [4:0]       lane_sh;
  logic             wr_en;
  logic [BUS_W-1:0] wr_mask32;
  logic [BUS_W-1:0] wr_data32;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_bits;
  logic [BUS_W-1:0] rd_word;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sync_in;
  logic             prime_c;

  // Lane 0 is the most significant byte, so shift = 8 * (3 - lane).
  assign grp       = AD[4:2];
  assign lane_sh   = {~AD[1:0], 3'b000};
  assign wr_en     = cs & ~rw;
  assign wr_mask32 = (BUS_W'(8'hFF) << lane_sh) & IMPL_MASK;
  assign wr_data32 = (BUS_W'(DI) << lane_sh) & wr_mask32;
  assign wr_mask   = WIDTH'(wr_mask32);
  assign wr_bits   = WIDTH'(wr_data32);

  // Output pins read back the driven value, never the pad.
  assign sync_in = (dir_q & out_q) | (~dir_q & sync2_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // DATA / DIR register updates
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_en && grp == GRP_DATA) out_d = (out_q & ~wr_mask) | wr_bits;
    if (wr_en && grp == GRP_DIR)  dir_d = (dir_q & ~wr_mask) | wr_bits;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  // Input synchroniser; on the priming cycle both stages load the pad
  // directly so the pipeline starts consistent with the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio;
      sync2_q <= prime_c ? gpio : sync1_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_set;
  logic             armed_q;
  logic             irq_q;

  assign prime_c = ~armed_q;
  assign irq     = irq_q;

  // Enables, edge capture and W1C status (set wins over clear)
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    edge_set  = '0;
    stat_d    = stat_q;
    if (wr_en && grp == GRP_RISE) rise_en_d = (rise_en_q & ~wr_mask) | wr_bits;
    if (wr_en && grp == GRP_FALL) fall_en_d = (fall_en_q & ~wr_mask) | wr_bits;
    if (armed_q) begin
      edge_set = (sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q);
    end
    if (wr_en && grp == GRP_STAT) stat_d = stat_q & ~wr_bits;
    stat_d = stat_d | edge_set;
    // While priming, prev takes the value sync_in will hold next cycle.
    prev_d = armed_q ? sync_in : ((dir_d & out_d) | (~dir_d & gpio));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      prev_q    <= '0;
      armed_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      prev_q    <= prev_d;
      armed_q   <= 1'b1;
      irq_q     <= |stat_q;
    end
  end
`else
  assign prime_c = 1'b0;
  assign irq     = 1'b0;
`endif

  // Read mux, zero-extended to 32 bits then lane-selected
  always_comb begin
    rd_word = '0;
    case (grp)
      GRP_DATA: rd_word = BUS_W'(sync_in);
      GRP_DIR:  rd_word = BUS_W'(dir_q);
`ifdef GPIO_IRQ_EN
      GRP_RISE: rd_word = BUS_W'(rise_en_q);
      GRP_FALL: rd_word = BUS_W'(fall_en_q);
      GRP_STAT: rd_word = BUS_W'(stat_q);
`endif
      GRP_OUT:  rd_word = BUS_W'(out_q);
      default:  rd_word = '0;
    endcase
  end

  assign DO = 8'(rd_word >> lane_sh);

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: self-checking bench for gpio_irq with WIDTH=12.
//   Table of register write/readback vectors, hand sequences for latency,
//   capture, set/clear collision, priming and reset, then a randomized run
//   against a per-pin value-history model. Builds with or without GPIO_IRQ_EN.
module tb_gpio_irq;

  localparam int unsigned W = 12;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0] wgrp;
    logic [1:0] lane;
    logic [7:0] wdata;
    logic [2:0] rgrp;
    logic [7:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   ad = '0;
  logic [7:0]   di = '0;
  logic [7:0]   dout;
  logic         rw = 1'b1;
  logic         cs = 1'b0;
  logic         irq;
  wire  [W-1:0] gpio;
  logic [W-1:0] tb_oe = '1;
  logic [W-1:0] tb_drv = '0;

  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_stat, m_padseen, m_view;

  vec_t        vtab[15];
  logic [7:0]  d;
  logic [31:0] t32;

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign gpio[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
  end

  gpio_irq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst_n),
    .AD  (ad),
    .DI  (di),
    .DO  (dout),
    .rw  (rw),
    .cs  (cs),
    .gpio(gpio),
    .irq (irq)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] g, input logic [1:0] l, input logic [7:0] b);
    @(negedge clk);
    ad = {g, l}; di = b; cs = 1'b1; rw = 1'b0;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] g, input logic [1:0] l, output logic [7:0] b);
    @(negedge clk);
    ad = {g, l}; cs = 1'b1; rw = 1'b1;
    #1;
    b = dout;
    cs = 1'b0;
  endtask

  function automatic logic [W-1:0] setbyte(input logic [W-1:0] cur, input int l, input logic [7:0] b);
    logic [31:0] t;
    t = 32'(cur);
    t[31-8*l -: 8] = b;
    return W'(t);
  endfunction

  function automatic logic [7:0] getbyte(input logic [W-1:0] v, input int l);
    logic [31:0] t;
    t = 32'(v);
    return t[31-8*l -: 8];
  endfunction

  // Every change of the value software would read on a pin is an edge.
  task automatic apply_view();
    logic [W-1:0] nv;
    nv = (m_out & m_dir) | (m_padseen & ~m_dir);
    if (IRQ_ON) m_stat = m_stat | (nv & ~m_view & m_rise) | (~nv & m_view & m_fall);
    m_view = nv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    m_padseen = W'($urandom);
    tb_oe = '1;
    tb_drv = m_padseen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_view = m_padseen;
  endtask

  initial begin
    vtab[0]  = '{3'd1, 2'd0, 8'hFF, 3'd1, 8'h00};
    vtab[1]  = '{3'd1, 2'd1, 8'hFF, 3'd1, 8'h00};
    vtab[2]  = '{3'd1, 2'd2, 8'hFF, 3'd1, 8'h0F};
    vtab[3]  = '{3'd1, 2'd3, 8'hFF, 3'd1, 8'hFF};
    vtab[4]  = '{3'd0, 2'd0, 8'hFF, 3'd5, 8'h00};
    vtab[5]  = '{3'd0, 2'd1, 8'hFF, 3'd5, 8'h00};
    vtab[6]  = '{3'd0, 2'd2, 8'hFF, 3'd5, 8'h0F};
    vtab[7]  = '{3'd0, 2'd3, 8'hFF, 3'd5, 8'hFF};
    vtab[8]  = '{3'd0, 2'd3, 8'hFF, 3'd0, 8'hFF};
    vtab[9]  = '{3'd5, 2'd3, 8'h00, 3'd5, 8'hFF};
    vtab[10] = '{3'd6, 2'd3, 8'hFF, 3'd6, 8'h00};
    vtab[11] = '{3'd7, 2'd2, 8'hFF, 3'd7, 8'h00};
    vtab[12] = '{3'd2, 2'd3, 8'h33, 3'd2, IRQ_ON ? 8'h33 : 8'h00};
    vtab[13] = '{3'd3, 2'd2, 8'hFF, 3'd3, IRQ_ON ? 8'h0F : 8'h00};
    vtab[14] = '{3'd4, 2'd3, 8'hFF, 3'd4, 8'h00};

    // Reset state: every group reads 0 even with pads active
    tb_oe = '1;
    tb_drv = 12'h0A5;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 8; g++) begin
      rd(3'(g), 2'd3, d);
      chk($sformatf("reset_grp%0d", g), 32'(d), 32'h0);
    end
    chk("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    tb_drv = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Register vectors
    for (int i = 0; i < 15; i++) begin
      wr(vtab[i].wgrp, vtab[i].lane, vtab[i].wdata);
      if (vtab[i].wgrp == 3'd1) begin
        t32 = '0;
        t32[31-8*int'(vtab[i].lane) -: 8] = vtab[i].wdata;
        tb_oe = tb_oe & ~W'(t32);
      end
      rd(vtab[i].rgrp, vtab[i].lane, d);
      chk($sformatf("vec%0d", i), 32'(d), 32'(vtab[i].exp));
    end
    chk("pads_driven", 32'(gpio), 32'hFFF);
    chk("irq_idle", 32'(irq), 32'h0);

    // Direction readback and synchroniser latency
    wr(3'd2, 2'd3, 8'h00);
    wr(3'd3, 2'd2, 8'h00);
    wr(3'd1, 2'd2, 8'h00);
    tb_oe = 12'hF00; tb_drv = '0;
    wr(3'd1, 2'd3, 8'hF0);
    tb_oe = 12'hF0F;
    wr(3'd0, 2'd3, 8'hA5);
    wr(3'd0, 2'd2, 8'h00);
    repeat (3) @(negedge clk);
    tb_drv = 12'h003;
    rd(3'd0, 2'd3, d);
    chk("dir_rb_k", 32'(d), 32'hA0);
    rd(3'd0, 2'd3, d);
    chk("dir_rb_k1", 32'(d), 32'hA3);
    rd(3'd0, 2'd2, d);
    chk("dir_rb_hi", 32'(d), 32'h00);
    wr(3'd4, 2'd2, 8'hFF);
    wr(3'd4, 2'd3, 8'hFF);

`ifdef GPIO_IRQ_EN
    // Rising capture latency and W1C
    @(negedge clk);
    tb_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    wr(3'd2, 2'd3, 8'h01);
    @(negedge clk);
    tb_drv[0] = 1'b1;
    rd(3'd4, 2'd3, d);
    chk("rise_stat_k", 32'(d), 32'h00);
    rd(3'd4, 2'd3, d);
    chk("rise_stat_k1", 32'(d), 32'h00);
    rd(3'd4, 2'd3, d);
    chk("rise_stat_k2", 32'(d), 32'h01);
    chk("rise_irq_k2", 32'(irq), 32'h0);
    @(negedge clk);
    chk("rise_irq_k3", 32'(irq), 32'h1);
    wr(3'd4, 2'd3, 8'h01);
    rd(3'd4, 2'd3, d);
    chk("w1c_stat", 32'(d), 32'h00);
    chk("w1c_irq_w", 32'(irq), 32'h1);
    @(negedge clk);
    chk("w1c_irq_w1", 32'(irq), 32'h0);

    // Set beats clear in the same cycle
    wr(3'd3, 2'd3, 8'h04);
    tb_drv[2] = 1'b1;
    repeat (4) @(negedge clk);
    tb_drv[2] = 1'b0;
    repeat (4) @(negedge clk);
    rd(3'd4, 2'd3, d);
    chk("fall_stat", 32'(d), 32'h04);
    chk("fall_irq", 32'(irq), 32'h1);
    tb_drv[2] = 1'b1;
    repeat (4) @(negedge clk);
    tb_drv[2] = 1'b0;
    @(negedge clk);
    wr(3'd4, 2'd3, 8'h04);
    rd(3'd4, 2'd3, d);
    chk("collide_stat", 32'(d), 32'h04);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("collide_irq%0d", i), 32'(irq), 32'h1);
    end
`endif

    // Mid-operation reset, pad5 held high through it
    @(negedge clk);
    rst_n = 1'b0;
    tb_oe = '1;
    tb_drv = 12'h020;
    rd(3'd4, 2'd3, d);
    chk("midrst_stat", 32'(d), 32'h00);
    rd(3'd1, 2'd3, d);
    chk("midrst_dir", 32'(d), 32'h00);
    chk("midrst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef GPIO_IRQ_EN
    // Priming: no edge from a pin already high at release
    wr(3'd2, 2'd3, 8'h20);
    repeat (5) @(negedge clk);
    rd(3'd4, 2'd3, d);
    chk("prime_stat", 32'(d), 32'h00);
    chk("prime_irq", 32'(irq), 32'h0);
    tb_drv[5] = 1'b0;
    repeat (4) @(negedge clk);
    rd(3'd4, 2'd3, d);
    chk("prime_fall_stat", 32'(d), 32'h00);
    tb_drv[5] = 1'b1;
    repeat (4) @(negedge clk);
    rd(3'd4, 2'd3, d);
    chk("prime_rise_stat", 32'(d), 32'h20);
    chk("prime_rise_irq", 32'(irq), 32'h1);
`else
    // Interrupt logic absent: groups 2-4 inert, irq stays low
    wr(3'd2, 2'd3, 8'hFF);
    wr(3'd3, 2'd2, 8'hFF);
    wr(3'd4, 2'd3, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tb_drv = tb_drv ^ 12'hFFF;
      chk($sformatf("off_irq%0d", i), 32'(irq), 32'h0);
    end
    repeat (3) @(negedge clk);
    for (int g = 2; g < 5; g++) begin
      rd(3'(g), 2'd3, d);
      chk($sformatf("off_grp%0d", g), 32'(d), 32'h00);
    end
    rd(3'd0, 2'd3, d);
    chk("off_data", 32'(d), 32'(tb_drv[7:0]));
`endif

    // Randomized run against the model
    do_reset();
    for (int s = 0; s < 30; s++) begin
      logic [W-1:0] was_out;
      logic [15:0]  clr;
      if (IRQ_ON) begin
        for (int l = 2; l < 4; l++) begin
          d = 8'($urandom);
          wr(3'd2, 2'(l), d);
          m_rise = setbyte(m_rise, l, d);
          d = 8'($urandom);
          wr(3'd3, 2'(l), d);
          m_fall = setbyte(m_fall, l, d);
        end
      end
      for (int l = 0; l < 4; l++) begin
        d = 8'($urandom);
        wr(3'd1, 2'(l), d);
        was_out = m_dir;
        m_dir = setbyte(m_dir, l, d);
        // A pin just released keeps reading its last driven value.
        m_padseen = (m_padseen & ~(was_out & ~m_dir)) | (m_out & was_out & ~m_dir);
        tb_oe = ~m_dir;
        tb_drv = m_padseen;
        apply_view();
      end
      for (int l = 0; l < 4; l++) begin
        d = 8'($urandom);
        wr(3'd0, 2'(l), d);
        m_out = setbyte(m_out, l, d);
        apply_view();
      end
      @(negedge clk);
      m_padseen = (m_padseen & m_dir) | (W'($urandom) & ~m_dir);
      tb_drv = m_padseen;
      apply_view();
      repeat (4) @(posedge clk);
      for (int l = 0; l < 4; l++) begin
        rd(3'd0, 2'(l), d);
        chk($sformatf("rnd%0d_data_l%0d", s, l), 32'(d), 32'(getbyte(m_view, l)));
      end
      rd(3'd1, 2'd2, d);
      chk($sformatf("rnd%0d_dir_l2", s), 32'(d), 32'(getbyte(m_dir, 2)));
      rd(3'd1, 2'd3, d);
      chk($sformatf("rnd%0d_dir_l3", s), 32'(d), 32'(getbyte(m_dir, 3)));
      rd(3'd5, 2'd3, d);
      chk($sformatf("rnd%0d_out_l3", s), 32'(d), 32'(getbyte(m_out, 3)));
      rd(3'd4, 2'd2, d);
      chk($sformatf("rnd%0d_stat_l2", s), 32'(d), 32'(getbyte(m_stat, 2)));
      rd(3'd4, 2'd3, d);
      chk($sformatf("rnd%0d_stat_l3", s), 32'(d), 32'(getbyte(m_stat, 3)));
      chk($sformatf("rnd%0d_irq", s), 32'(irq), 32'(|m_stat));
      clr = 16'($urandom);
      wr(3'd4, 2'd2, clr[15:8]);
      wr(3'd4, 2'd3, clr[7:0]);
      m_stat = m_stat & ~W'(clr);
      repeat (2) @(negedge clk);
      chk($sformatf("rnd%0d_irq_clr", s), 32'(irq), 32'(|m_stat));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
